// File: rtl/seq_boothmul.sv
// Sequential radix-4 Booth multiplier: one Booth digit per clock, start/busy/done handshake,
// signed or unsigned operands, full 2*DATA_WIDTH product registered on completion.
module seq_boothmul #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      is_signed,
    input  logic [DATA_WIDTH-1:0]     Q,
    input  logic [DATA_WIDTH-1:0]     M,
    output logic                      busy,
    output logic                      done,
    output logic [2*DATA_WIDTH-1:0]   A
);

    localparam int N_ITER = (DATA_WIDTH + 2) / 2;
    localparam int ACC_W  = 2 * DATA_WIDTH + 4;
    localparam int MR_W   = DATA_WIDTH + 3;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  mcand_reg;
    logic [MR_W-1:0]   mplier_reg;

    logic [ACC_W-1:0]  row_next;
    logic              neg_next;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  q_ext_next;
    logic [MR_W-1:0]   m_ext_next;
    logic              q_fill;
    logic              m_fill;

    // Operand extension: the multiplicand fills the whole accumulator width so later
    // left shifts keep the sign; the multiplier gains two extension bits and an implicit 0 LSB.
    assign q_fill = is_signed & Q[DATA_WIDTH-1];
    assign m_fill = is_signed & M[DATA_WIDTH-1];

    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_q_ext
            if (gi < DATA_WIDTH) begin : g_data
                assign q_ext_next[gi] = Q[gi];
            end else begin : g_fill
                assign q_ext_next[gi] = q_fill;
            end
        end
    endgenerate

    assign m_ext_next = {m_fill, m_fill, M, 1'b0};

    // Booth digit decode on the low three bits of the right-shifting multiplier.
    always_comb begin
        row_next = '0;
        neg_next = 1'b0;
        case (mplier_reg[2:0])
            3'b001, 3'b010: begin
                row_next = mcand_reg;
                neg_next = 1'b0;
            end
            3'b011: begin
                row_next = mcand_reg << 1;
                neg_next = 1'b0;
            end
            3'b100: begin
                row_next = mcand_reg << 1;
                neg_next = 1'b1;
            end
            3'b101, 3'b110: begin
                row_next = mcand_reg;
                neg_next = 1'b1;
            end
            default: begin
                row_next = '0;
                neg_next = 1'b0;
            end
        endcase
    end

    // Subtraction as inverted row plus a carry-in at the LSB.
    assign acc_next = acc_reg + (neg_next ? ~row_next : row_next) + {{(ACC_W-1){1'b0}}, neg_next};

    // The done pulse is registered from the DONE state, so it appears while the FSM is
    // already back in IDLE; start is ignored during that pulse cycle as well.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg  <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            A          <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && !done) begin
                        mcand_reg  <= q_ext_next;
                        mplier_reg <= m_ext_next;
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        busy       <= 1'b1;
                        state_reg  <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 2;
                    mplier_reg <= mplier_reg >> 2;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_CNT) begin
                        A         <= acc_next[2*DATA_WIDTH-1:0];
                        busy      <= 1'b0;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_boothmul.sv
// Self-checking bench for seq_boothmul: scoreboard of reference products pushed at start
// and popped at done, plus handshake, latency and clear-abort scenarios.
module tb_seq_boothmul;

    localparam int DW      = 32;
    localparam int N_ITER  = (DW + 2) / 2;
    localparam int LATENCY = N_ITER + 2;
    localparam int TIMEOUT = 100;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [DW-1:0] Q = '0;
    logic [DW-1:0] M = '0;
    logic          busy;
    logic          done;
    logic [2*DW-1:0] A;

    int checks   = 0;
    int failures = 0;
    logic [2*DW-1:0] exp_q[$];

    seq_boothmul #(.DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .is_signed (is_signed),
        .Q         (Q),
        .M         (M),
        .busy      (busy),
        .done      (done),
        .A         (A)
    );

    always #5 clock = ~clock;

    function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] q, input logic [DW-1:0] m,
                                               input logic s);
        logic signed [2*DW-1:0] qx;
        logic signed [2*DW-1:0] mx;
        qx = s ? {{DW{q[DW-1]}}, q} : {{DW{1'b0}}, q};
        mx = s ? {{DW{m[DW-1]}}, m} : {{DW{1'b0}}, m};
        return qx * mx;
    endfunction

    // Drives a one-cycle start pulse and records the expected product; returns at the
    // negedge following the edge that sampled start.
    task automatic issue(input logic [DW-1:0] q, input logic [DW-1:0] m, input logic s);
        @(negedge clock);
        Q = q;
        M = m;
        is_signed = s;
        start = 1'b1;
        exp_q.push_back(ref_mul(q, m, s));
        @(negedge clock);
        start = 1'b0;
    endtask

    // Counts negedges until done is seen; busy_cnt counts negedges with busy high.
    task automatic wait_done(output int lat, output int busy_cnt, output bit ok);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < TIMEOUT) begin
            @(negedge clock);
            lat++;
            if (busy) busy_cnt++;
        end
        ok = done;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || A !== '0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b A=%h required busy=0 done=0 A=0", busy, done, A);
        end
        clear = 1'b0;
        $display("reset: busy=%b done=%b A=%h", busy, done, A);
    endtask

    task automatic test_signed_basic();
        int lat, bcnt;
        bit ok;
        logic [2*DW-1:0] exp;
        issue(32'd6, 32'd7, 1'b1);
        wait_done(lat, bcnt, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_timeout: no done within %0d cycles", TIMEOUT);
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (lat + 1 !== LATENCY) begin
            failures++;
            $display("FAIL basic_latency: got %0d required %0d", lat + 1, LATENCY);
        end
        checks++;
        if (bcnt !== N_ITER) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d required %0d", bcnt, N_ITER);
        end
        checks++;
        if (A !== exp || exp !== 64'h000000000000002A) begin
            failures++;
            $display("FAIL basic_product: A=%h required %h", A, 64'h000000000000002A);
        end
        checks++;
        @(negedge clock);
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL basic_done_pulse: done=%b required 0 one cycle after", done);
        end
        $display("basic: 6*7 signed A=%h latency=%0d busy_cycles=%0d", A, lat + 1, bcnt);
    endtask

    // Runs one op through the scoreboard and compares against the popped expectation.
    task automatic test_scoreboard_op(input string name, input logic [DW-1:0] q,
                                      input logic [DW-1:0] m, input logic s,
                                      input logic [2*DW-1:0] fixed_exp, input bit use_fixed);
        int lat, bcnt;
        bit ok;
        logic [2*DW-1:0] exp;
        issue(q, m, s);
        wait_done(lat, bcnt, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, TIMEOUT);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        if (use_fixed) exp = fixed_exp;
        checks++;
        if (A !== exp) begin
            failures++;
            $display("FAIL %s: Q=%h M=%h s=%b A=%h required %h", name, q, m, s, A, exp);
        end
        if (use_fixed) $display("%s: Q=%h M=%h s=%b A=%h", name, q, m, s, A);
    endtask

    task automatic test_signed_negative();
        test_scoreboard_op("neg_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFFFFFFFFF1, 1'b1);
        test_scoreboard_op("neg_m1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 1'b1);
    endtask

    task automatic test_extremes();
        test_scoreboard_op("unsigned_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        test_scoreboard_op("signed_minmin", 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
        test_scoreboard_op("unsigned_min_x_max", 32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h7FFFFFFF80000000, 1'b1);
    endtask

    task automatic test_handshake();
        int lat, bcnt, extra_done, busy_seen;
        bit ok, a_changed;
        logic [2*DW-1:0] exp;
        issue(32'd3, 32'd4, 1'b0);
        Q = 32'd9;
        M = 32'd9;
        is_signed = 1'b1;
        start = 1'b1;
        repeat (4) @(negedge clock);
        start = 1'b0;
        Q = 32'hDEADBEEF;
        M = 32'h12345678;
        wait_done(lat, bcnt, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL handshake_timeout: no done within %0d cycles", TIMEOUT);
            void'(exp_q.pop_front());
            return;
        end
        exp = exp_q.pop_front();
        checks++;
        if (A !== exp || exp !== 64'd12) begin
            failures++;
            $display("FAIL handshake_product: A=%h required %h", A, 64'd12);
        end
        // start during the done pulse must be ignored
        start = 1'b1;
        Q = 32'd9;
        M = 32'd9;
        @(negedge clock);
        start = 1'b0;
        extra_done = 0;
        busy_seen = 0;
        a_changed = 1'b0;
        repeat (LATENCY + 6) begin
            if (done) extra_done++;
            if (busy) busy_seen++;
            if (A !== 64'd12) a_changed = 1'b1;
            @(negedge clock);
        end
        checks++;
        if (extra_done !== 0 || busy_seen !== 0) begin
            failures++;
            $display("FAIL handshake_ignored_start: extra_done=%0d busy_cycles=%0d required 0 and 0",
                     extra_done, busy_seen);
        end
        checks++;
        if (a_changed) begin
            failures++;
            $display("FAIL handshake_a_hold: A=%h required %h held", A, 64'd12);
        end
        $display("handshake: 3*4 A=%h extra_done=%0d", A, extra_done);
    endtask

    task automatic test_clear_mid();
        int extra_done;
        issue(32'd100, 32'd100, 1'b1);
        repeat (7) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_mid_running: busy=%b required 1", busy);
        end
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        exp_q.delete();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || A !== '0) begin
            failures++;
            $display("FAIL clear_mid_state: busy=%b done=%b A=%h required 0 0 0", busy, done, A);
        end
        extra_done = 0;
        repeat (LATENCY + 4) begin
            @(negedge clock);
            if (done || busy) extra_done++;
        end
        checks++;
        if (extra_done !== 0) begin
            failures++;
            $display("FAIL clear_mid_no_done: activity_cycles=%0d required 0", extra_done);
        end
        $display("clear_mid: aborted op, busy=%b done=%b A=%h", busy, done, A);
        test_scoreboard_op("clear_then_fresh", 32'd100, 32'd100, 1'b1, 64'd10000, 1'b1);
    endtask

    task automatic test_random();
        logic [DW-1:0] q, m;
        logic s;
        int f0;
        f0 = failures;
        for (int i = 0; i < 200; i++) begin
            q = $urandom();
            m = $urandom();
            s = 1'($urandom_range(0, 1));
            case (i % 10)
                0: q = 32'h7FFFFFFF;
                1: m = 32'h80000000;
                2: q = '0;
                default: ;
            endcase
            test_scoreboard_op("random", q, m, s, '0, 1'b0);
        end
        $display("random: 200 ops, new_failures=%0d", failures - f0);
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_signed_negative();
        test_extremes();
        test_handshake();
        test_clear_mid();
        test_random();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
